// File: rtl/pacman_soc_nios2_processor_cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator for the Nios II debug slave: one {IR, DR} scan per accepted command.
// Define SCAN_MASTER_IR_CACHE_EN to skip the UIR phase when the IR repeats the last one shifted.
module pacman_soc_nios2_processor_cpu_debug_scan_master #(
  parameter int IR_WIDTH   = 2,
  parameter int DR_WIDTH   = 38,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int DIV_W   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
  localparam logic [CNT_W-1:0] DR_LAST  = CNT_W'(DR_WIDTH - 1);
  localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [DR_WIDTH-1:0] sr;
  logic                accept, tick, rise, fall, done, skip_uir;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = !busy && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;

  // tick marks the clk edge on which vji_tck toggles; its direction names the event.
  assign tick = busy && (div_cnt == DIV_LAST);
  assign rise = tick && !vji_tck;
  assign fall = tick && vji_tck;

  // Strobes decode the state register, so they change exactly when the state does.
  assign vji_uir = (state == S_UIR);
  assign vji_cdr = (state == S_CDR);
  assign vji_sdr = (state == S_SDR);
  assign vji_udr = (state == S_UDR);
  assign vji_rti = (state == S_RTI);

`ifdef SCAN_MASTER_IR_CACHE_EN
  logic                cache_valid;
  logic [IR_WIDTH-1:0] cache_ir;

  assign skip_uir = cache_valid && (cache_ir == cmd_ir);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_ir    <= '0;
    end else if (fall && (state == S_UIR)) begin
      cache_valid <= 1'b1;
      cache_ir    <= vji_ir_in;
    end
  end
`else
  assign skip_uir = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = skip_uir ? S_CDR : S_UIR;
      end
      S_UIR: begin
        if (fall) state_nxt = S_CDR;
      end
      S_CDR: begin
        if (fall) begin
          state_nxt = S_SDR;
          cnt_nxt   = '0;
        end
      end
      S_SDR: begin
        if (fall) begin
          if (cnt == DR_LAST) state_nxt = S_UDR;
          else                cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      S_UDR: begin
        if (fall) begin
          state_nxt = S_RTI;
          cnt_nxt   = '0;
        end
      end
      S_RTI: begin
        if (fall) begin
          if (cnt == RTI_LAST) begin
            state_nxt = S_IDLE;
            done      = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      vji_tck <= 1'b0;
    end else if (!busy) begin
      div_cnt <= '0;
      vji_tck <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      vji_tck <= !vji_tck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // tdi is launched on falls and the slave's tdo is captured on rises, half a tck apart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
    end else begin
      if (accept) begin
        sr        <= cmd_dr;
        vji_ir_in <= cmd_ir;
      end else if (rise && (state == S_SDR)) begin
        sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
      end
      if (fall) vji_tdi <= (state_nxt == S_SDR) ? sr[0] : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sr;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pacman_soc_nios2_processor_cpu_debug_scan_master.sv
// Self-checking bench: looped-back slave model, strobe/tdi monitor, table-driven and random scans.
module tb_pacman_soc_nios2_processor_cpu_debug_scan_master;

  localparam int IRW      = 2;
  localparam int DRW      = 38;
  localparam int DIV      = 2;
  localparam int RTI      = 2;
  localparam int PERIOD   = 2 * DIV;
  localparam int FULL_LAT = (3 + DRW + RTI) * PERIOD;

  typedef struct {
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr;
    logic [DRW-1:0] pre;
    logic [DRW-1:0] exp_rsp;
    logic [DRW-1:0] exp_slave;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic           cmd_valid = 1'b0;
  logic           rsp_ready = 1'b0;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, vji_tdo;
  logic [DRW-1:0] rsp_data;
  logic [IRW-1:0] vji_ir_in;
  logic           vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [4:0]     strb;

  logic       s_cmd_valid = 1'b0;
  logic       s_rsp_ready = 1'b0;
  logic [1:0] s_cmd_ir = '0;
  logic [1:0] s_cmd_dr = '0;
  logic       s_cmd_ready, s_rsp_valid, s_busy, s_vji_tck, s_vji_tdi, s_vji_tdo;
  logic [1:0] s_rsp_data, s_vji_ir_in;
  logic       s_uir, s_cdr, s_sdr, s_udr, s_rti;

  // Slave models and monitor state, owned by the monitor process.
  logic [DRW-1:0] slave_sr = '0;
  logic [1:0]     s_slave = '0;
  logic [DRW-1:0] slave_preload = '0;
  logic [1:0]     s_preload = '0;
  int             load_seq = 0;
  int             load_seen = 0;
  int cyc = 0, accepts = 0, viol = 0, uir_clks = 0;
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
  int s_last_rise = 0, s_period = 0;
  logic tck_prev = 1'b0, tdi_prev = 1'b0, s_tck_prev = 1'b0;
  logic [IRW-1:0] last_uir_ir = '0;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SCAN_MASTER_IR_CACHE_EN
  logic           m_cache_valid = 1'b0;
  logic [IRW-1:0] m_cache_ir = '0;
`endif

  assign vji_tdo   = slave_sr[0];
  assign s_vji_tdo = s_slave[0];
  assign strb      = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};

  always #5 clk = ~clk;

  pacman_soc_nios2_processor_cpu_debug_scan_master #(
    .IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(DIV), .RTI_CYCLES(RTI)
  ) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  pacman_soc_nios2_processor_cpu_debug_scan_master #(
    .IR_WIDTH(2), .DR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1)
  ) u_small (
    .clk(clk), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ir(s_cmd_ir), .cmd_dr(s_cmd_dr),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .busy(s_busy),
    .vji_tck(s_vji_tck), .vji_tdi(s_vji_tdi), .vji_tdo(s_vji_tdo), .vji_ir_in(s_vji_ir_in),
    .vji_uir(s_uir), .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_rti(s_rti)
  );

  // Monitor: slave shift registers, strobe one-hot, tdi stability and per-strobe rise counts.
  always @(negedge clk) begin : monitor
    int   v;
    logic rise_m, rise_s;
    v      = 0;
    rise_m = !tck_prev && vji_tck;
    rise_s = !s_tck_prev && s_vji_tck;
    if (busy ? ($countones(strb) != 1) : (strb != 5'b0)) v++;
    if (!vji_sdr && vji_tdi) v++;
    if (rise_m && (vji_tdi !== tdi_prev)) v++;
    viol <= viol + v;
    cyc  <= cyc + 1;
    if (cmd_valid && cmd_ready) accepts <= accepts + 1;
    if (vji_uir) begin
      uir_clks    <= uir_clks + 1;
      last_uir_ir <= vji_ir_in;
    end
    if (rise_m) begin
      n_uir <= n_uir + int'(vji_uir);
      n_cdr <= n_cdr + int'(vji_cdr);
      n_sdr <= n_sdr + int'(vji_sdr);
      n_udr <= n_udr + int'(vji_udr);
      n_rti <= n_rti + int'(vji_rti);
    end
    if (load_seq != load_seen) begin
      slave_sr  <= slave_preload;
      s_slave   <= s_preload;
      load_seen <= load_seq;
    end else begin
      if (rise_m && vji_sdr) slave_sr <= {vji_tdi, slave_sr[DRW-1:1]};
      if (rise_s && s_sdr)   s_slave  <= {s_vji_tdi, s_slave[1]};
    end
    if (rise_s) begin
      s_period    <= cyc - s_last_rise;
      s_last_rise <= cyc;
    end
    tck_prev   <= vji_tck;
    tdi_prev   <= vji_tdi;
    s_tck_prev <= s_vji_tck;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DRW-1:0] rnd_dr();
    return DRW'({$urandom(), $urandom()});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    lat = 0;
    while (!rsp_valid && lat < budget) begin
      step();
      lat++;
    end
  endtask

  task automatic load_slaves(input logic [DRW-1:0] pre, input logic [1:0] s_pre);
    slave_preload = pre;
    s_preload     = s_pre;
    load_seq++;
    @(negedge clk);
    step();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
`ifdef SCAN_MASTER_IR_CACHE_EN
    m_cache_valid = 1'b0;
`endif
  endtask

  // One full scan through the loopback slave, checked against the scan rules and the IR-cache model.
  task automatic run_scan(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                          input logic [DRW-1:0] pre, input logic [DRW-1:0] exp_rsp,
                          input logic [DRW-1:0] exp_slave, input string tag,
                          output int lat, output int uir_seen);
    int  a0, u0, c0, s0, d0, r0, uc0, v0, w, gap;
    bit  exp_uir;
    int  exp_lat;
    exp_uir = 1'b1;
`ifdef SCAN_MASTER_IR_CACHE_EN
    exp_uir = !(m_cache_valid && m_cache_ir == ir);
`endif
    exp_lat = exp_uir ? FULL_LAT : FULL_LAT - PERIOD;
    load_slaves(pre, 2'b00);
    a0 = accepts; u0 = n_uir; c0 = n_cdr; s0 = n_sdr; d0 = n_udr; r0 = n_rti;
    uc0 = uir_clks; v0 = viol;
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 64) begin
      step();
      w++;
    end
    step();
    cmd_valid = 1'b0;
    wait_rsp(FULL_LAT + 20, lat);
    uir_seen = n_uir - u0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    check({tag, " slave holds dr"}, 64'(slave_sr), 64'(exp_slave));
    check({tag, " uir rises"}, 64'(uir_seen), 64'(int'(exp_uir)));
    check({tag, " uir clks"}, 64'(uir_clks - uc0), 64'(exp_uir ? PERIOD : 0));
    check({tag, " cdr/udr rises"}, 64'({n_cdr - c0, n_udr - d0}), {32'd1, 32'd1});
    check({tag, " sdr rises"}, 64'(n_sdr - s0), 64'(DRW));
    check({tag, " rti rises"}, 64'(n_rti - r0), 64'(RTI));
    check({tag, " accepts"}, 64'(accepts - a0), 64'd1);
    check({tag, " strobe/tdi violations"}, 64'(viol - v0), 64'd0);
    if (exp_uir) check({tag, " ir during uir"}, 64'(last_uir_ir), 64'(ir));
    gap = int'($urandom_range(0, 3));
    repeat (gap) step();
    check({tag, " rsp held {valid,ready}"}, 64'({rsp_valid, cmd_ready}), 64'(2'b10));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " after rsp_ready {valid,ready,busy}"}, 64'({rsp_valid, cmd_ready, busy}),
          64'(3'b010));
`ifdef SCAN_MASTER_IR_CACHE_EN
    if (exp_uir) begin
      m_cache_valid = 1'b1;
      m_cache_ir    = ir;
    end
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t           vecs [8];
    int             lat, nu, a0, s0, w, seen;
    logic [DRW-1:0] pre, dr;
    logic [1:0]     sp, sd;

    vecs[0] = '{2'b01, 38'h15_1234_5678, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 38'h15_1234_5678};
    vecs[1] = '{2'b00, '0, '1, '1, '0};
    vecs[2] = '{2'b11, '1, '0, '0, '1};
    for (int i = 3; i < 8; i++) begin
      dr      = rnd_dr();
      pre     = rnd_dr();
      vecs[i] = '{IRW'($urandom_range(0, 3)), dr, pre, pre, dr};
    end

    #1;
    check("reset {ready,rvalid,busy,tck,tdi,strobes}",
          64'({cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, strb}), 64'(10'b10_0000_0000));
    check("reset rsp_data/ir_in", 64'({rsp_data, vji_ir_in}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_scan(vecs[i].ir, vecs[i].dr, vecs[i].pre, vecs[i].exp_rsp, vecs[i].exp_slave,
               $sformatf("vec%0d", i), lat, nu);

    // cmd_valid held through a scan and through a pending response
    load_slaves(rnd_dr(), 2'b00);
    a0 = accepts;
    cmd_ir = 2'b10; cmd_dr = rnd_dr(); cmd_valid = 1'b1;
    wait_rsp(FULL_LAT + 40, lat);
    check("held valid: rsp_valid reached", 64'(rsp_valid), 64'd1);
    repeat (6) step();
    check("held valid: pending {valid,ready,accepts}", 64'({rsp_valid, cmd_ready, accepts - a0}),
          64'({1'b1, 1'b0, 32'd1}));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("held valid: clear edge {valid,ready,accepts}", 64'({rsp_valid, cmd_ready, accepts - a0}),
          64'({1'b0, 1'b1, 32'd1}));
    step();
    cmd_valid = 1'b0;
    check("held valid: next accept {busy,accepts}", 64'({busy, accepts - a0}), 64'({1'b1, 32'd2}));
    wait_rsp(FULL_LAT + 20, lat);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`ifdef SCAN_MASTER_IR_CACHE_EN
    m_cache_valid = 1'b1;
    m_cache_ir    = 2'b10;
`endif

    // Reset in the middle of the DR shift
    load_slaves(rnd_dr(), 2'b00);
    s0 = n_sdr;
    cmd_ir = 2'b01; cmd_dr = rnd_dr(); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    w = 0;
    while ((n_sdr - s0) < 17 && w < 400) begin
      step();
      w++;
    end
    check("mid-scan reached sdr bit 17", 64'(n_sdr - s0), 64'd17);
    #2 reset = 1'b1;
    #1;
    check("async reset {ready,rvalid,busy,tck,tdi,strobes}",
          64'({cmd_ready, rsp_valid, busy, vji_tck, vji_tdi, strb}), 64'(10'b10_0000_0000));
    check("async reset rsp_data/ir_in", 64'({rsp_data, vji_ir_in}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
`ifdef SCAN_MASTER_IR_CACHE_EN
    m_cache_valid = 1'b0;
`endif
    seen = 0;
    repeat (200) begin
      step();
      if (rsp_valid || busy) seen++;
    end
    check("no response after aborted scan", 64'(seen), 64'd0);
    pre = rnd_dr();
    dr  = rnd_dr();
    run_scan(2'b01, dr, pre, pre, dr, "post-reset", lat, nu);

    // IR cache behaviour
    pre = rnd_dr();
    dr  = rnd_dr();
    run_scan(2'b10, dr, pre, pre, dr, "ir10 first", lat, nu);
    run_scan(2'b10, pre, dr, dr, pre, "ir10 repeat", lat, nu);
`ifdef SCAN_MASTER_IR_CACHE_EN
    check("cache hit latency", 64'(lat), 64'd168);
    check("cache hit uir count", 64'(nu), 64'd0);
    run_scan(2'b11, dr, pre, pre, dr, "ir11 change", lat, nu);
    check("cache miss uir count", 64'(nu), 64'd1);
    do_reset();
    run_scan(2'b11, dr, pre, pre, dr, "ir11 after reset", lat, nu);
    check("after reset uir count", 64'(nu), 64'd1);
`else
    check("repeat ir latency", 64'(lat), 64'd172);
    check("repeat ir uir count", 64'(nu), 64'd1);
`endif

    // Minimal configuration: TCK_DIV=1, DR_WIDTH=2, RTI_CYCLES=1
    for (int k = 0; k < 3; k++) begin
      sp = (k == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      sd = (k == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      load_slaves(slave_preload, sp);
      s_cmd_ir = 2'b11; s_cmd_dr = sd; s_cmd_valid = 1'b1;
      w = 0;
      while (!s_cmd_ready && w < 16) begin
        step();
        w++;
      end
      step();
      s_cmd_valid = 1'b0;
      lat = 0;
      while (!s_rsp_valid && lat < 40) begin
        step();
        lat++;
      end
      check($sformatf("small%0d latency", k), 64'(lat), 64'd12);
      check($sformatf("small%0d rsp_data", k), 64'(s_rsp_data), 64'(sp));
      check($sformatf("small%0d slave holds dr", k), 64'(s_slave), 64'(sd));
      check($sformatf("small%0d tck period", k), 64'(s_period), 64'd2);
      s_rsp_ready = 1'b1;
      step();
      s_rsp_ready = 1'b0;
      check($sformatf("small%0d released", k), 64'({s_rsp_valid, s_cmd_ready}), 64'(2'b01));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
